// File: rtl/branch_resolve.sv
// branch_resolve
//   Resolves conditional branches from EX. An accepted branch is compared,
//   its target computed, and if taken and word-aligned a redirect is raised
//   one cycle later and held until fetch takes it. While a redirect is
//   outstanding, younger IF/ID work is flushed and EX input is ignored.
//
// Ports
//   clk, rst                : clock, synchronous active-high reset
//   ex_valid / ex_ready     : branch handshake from EX
//   branch_src              : 000 beq, 001 bne, 010 blt, 011 bge, 100 bltu, 101 bgeu
//   rs1_data, rs2_data      : compare operands (XLEN)
//   pc, imm                 : branch PC and sign-extended offset (XLEN)
//   redir_valid/ready/pc    : redirect handshake to fetch
//   flush                   : squash younger IF/ID instructions
//   illegal, misalign       : one-cycle error pulses
//   br_count, taken_count   : performance counters (CNT_W, wrapping)
module branch_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [2:0]       branch_src,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    input  logic             redir_ready,
    output logic             flush,
    output logic             illegal,
    output logic             misalign,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {IDLE = 1'b0, REDIRECT = 1'b1} state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic            bad_src;
    logic            cond;
    logic            aligned;
    logic            go;
    logic [XLEN-1:0] target;

    assign ex_ready    = (state == IDLE);
    assign redir_valid = (state == REDIRECT);
    assign flush       = (state == REDIRECT);

    // ex_valid during REDIRECT is wrong-path and never accepted.
    assign accept  = ex_valid && ex_ready;
    assign bad_src = (branch_src[2:1] == 2'b11);
    assign target  = pc + imm;
    assign aligned = (target[1:0] == 2'b00);

    always_comb begin
        cond = 1'b0;
        case (branch_src)
            3'b000:  cond = (rs1_data == rs2_data);
            3'b001:  cond = (rs1_data != rs2_data);
            3'b010:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b011:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b100:  cond = (rs1_data <  rs2_data);
            3'b101:  cond = (rs1_data >= rs2_data);
            default: cond = 1'b0;
        endcase
    end

    // Only a legal, taken, aligned branch produces a redirect.
    assign go = accept && !bad_src && cond && aligned;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (go)          state_nxt = REDIRECT;
            REDIRECT: if (redir_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_pc    <= '0;
            illegal     <= 1'b0;
            misalign    <= 1'b0;
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            illegal  <= accept && bad_src;
            misalign <= accept && !bad_src && cond && !aligned;
            // go only fires in IDLE, so redir_pc is frozen for the whole
            // REDIRECT stay regardless of redir_ready.
            if (go) begin
                redir_pc <= target;
            end
            if (accept) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (go) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid;
    logic             ex_ready;
    logic [2:0]       branch_src;
    logic [XLEN-1:0]  rs1_data, rs2_data, pc, imm;
    logic             redir_valid;
    logic [XLEN-1:0]  redir_pc;
    logic             redir_ready;
    logic             flush;
    logic             illegal, misalign;
    logic [CNT_W-1:0] br_count, taken_count;

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .branch_src(branch_src),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm(imm),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .flush(flush), .illegal(illegal), .misalign(misalign),
        .br_count(br_count), .taken_count(taken_count)
    );

    typedef struct packed {
        logic             rv;
        logic [XLEN-1:0]  pc;
        logic             ill;
        logic             mis;
        logic [CNT_W-1:0] br;
        logic [CNT_W-1:0] tk;
    } exp_t;

    exp_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic             m_redir = 1'b0;
    logic [XLEN-1:0]  m_pc    = '0;
    logic [CNT_W-1:0] m_br    = '0;
    logic [CNT_W-1:0] m_tk    = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] s, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (s)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd2:    return $signed(a) <  $signed(b);
            3'd3:    return $signed(a) >= $signed(b);
            3'd4:    return a <  b;
            3'd5:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive, predict, push; clock; pop, compare.
    task automatic step(input logic v, input logic [2:0] s,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] p, input logic [XLEN-1:0] i,
                        input logic rr, input logic r);
        exp_t            e;
        logic            acc, tk, ill, go;
        logic [XLEN-1:0] tgt;
        rst = r; ex_valid = v; branch_src = s; rs1_data = a; rs2_data = b;
        pc = p; imm = i; redir_ready = rr;
        #1;
        chk("ex_ready", 32'(ex_ready), 32'(!m_redir));
        acc = v && !m_redir;
        ill = (s == 3'b110) || (s == 3'b111);
        tk  = ref_cond(s, a, b);
        tgt = p + i;
        e   = '0;
        if (r) begin
            m_redir = 1'b0; m_pc = '0; m_br = '0; m_tk = '0;
        end else begin
            e.ill = acc && ill;
            e.mis = acc && !ill && tk && (tgt[1:0] != 2'b00);
            go    = acc && !ill && tk && (tgt[1:0] == 2'b00);
            if (m_redir) begin
                if (rr) m_redir = 1'b0;
            end else if (go) begin
                m_redir = 1'b1;
                m_pc    = tgt;
            end
            if (acc) m_br = m_br + 1'b1;
            if (go)  m_tk = m_tk + 1'b1;
        end
        e.rv = m_redir; e.pc = m_pc; e.br = m_br; e.tk = m_tk;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("redir_valid", 32'(redir_valid), 32'(e.rv));
        chk("flush",       32'(flush),       32'(e.rv));
        chk("redir_pc",    redir_pc,         e.pc);
        chk("illegal",     32'(illegal),     32'(e.ill));
        chk("misalign",    32'(misalign),    32'(e.mis));
        chk("br_count",    32'(br_count),    32'(e.br));
        chk("taken_count", 32'(taken_count), 32'(e.tk));
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 3'b000, '0, '0, '0, '0, rr, 1'b0);
    endtask

    initial begin
        logic [XLEN-1:0] a, b, i;
        // reset dominates a simultaneous taken beq
        @(negedge clk);
        step(1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1);
        step(1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b1);
        chk("rst_br_count", 32'(br_count), 32'd0);

        // beq taken, immediate accept by fetch
        step(1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 1'b0);
        chk("beq_redir_pc", redir_pc, 32'h120);
        idle(1'b1);

        // signed vs unsigned on the same operands
        step(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1, 1'b0);
        idle(1'b1);
        step(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40, 1'b1, 1'b0);
        idle(1'b1);

        // held redirect with wrong-path EX traffic
        step(1'b1, 3'b011, 32'd7, 32'd3, 32'h1000, 32'hFFFF_FF00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            step(1'b1, 3'b000, 32'd1, 32'd1, 32'h4000, 32'h8, 1'b0, 1'b0);
        chk("held_redir_pc", redir_pc, 32'h0F00);
        step(1'b0, 3'b000, '0, '0, '0, '0, 1'b1, 1'b0);
        idle(1'b0);

        // illegal encodings, misaligned taken bne, redir_ready in IDLE
        step(1'b1, 3'b110, 32'd1, 32'd1, 32'h100, 32'h4, 1'b1, 1'b0);
        step(1'b1, 3'b111, 32'd1, 32'd2, 32'h100, 32'h4, 1'b1, 1'b0);
        step(1'b1, 3'b001, 32'd1, 32'd2, 32'h100, 32'h2, 1'b1, 1'b0);
        step(1'b1, 3'b101, 32'd9, 32'd9, 32'h100, 32'h1, 1'b0, 1'b0);
        idle(1'b1);

        // reset while in REDIRECT
        step(1'b1, 3'b000, 32'd0, 32'd0, 32'h80, 32'h80, 1'b0, 1'b0);
        step(1'b1, 3'b000, 32'd0, 32'd0, 32'h80, 32'h80, 1'b0, 1'b1);
        idle(1'b0);

        // counter wrap with reduced CNT_W: 16 taken branches
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 3'b000, 32'd3, 32'd3, 32'(k * 16), 32'h10, 1'b0, 1'b0);
            idle(1'b1);
        end
        chk("wrap_taken_count", 32'(taken_count), 32'd0);
        chk("wrap_br_count",    32'(br_count),    32'd0);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            a = $urandom();
            b = ($urandom_range(0, 2) == 0) ? a : $urandom();
            i = $urandom();
            if ($urandom_range(0, 3) != 0) i[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, b,
                 $urandom() & 32'hFFFF_FFFC, i, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand/PC width.
REQ-002 SHALL provide parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ex_valid  input  1  EX-stage branch instruction present.
REQ-006 SHALL have port ex_ready  output  1  block can accept a branch this cycle.
REQ-007 SHALL have port branch_src  input  3  compare select: 000 beq, 001 bne, 010 blt, 011 bge, 100 bltu, 101 bgeu.
REQ-008 SHALL have ports rs1_data, rs2_data  input  XLEN  compare operands.
REQ-009 SHALL have ports pc, imm  input  XLEN  branch PC and sign-extended offset.
REQ-010 SHALL have port redir_valid  output  1  redirect request to fetch.
REQ-011 SHALL have port redir_pc  output  XLEN  redirect target.
REQ-012 SHALL have port redir_ready  input  1  fetch accepts redirect.
REQ-013 SHALL have port flush  output  1  squash younger IF/ID instructions.
REQ-014 SHALL have ports illegal, misalign  output  1 each  one-cycle error pulses.
REQ-015 SHALL have ports br_count, taken_count  output  CNT_W each  performance counters.

Function
REQ-016 SHALL implement FSM states IDLE and REDIRECT; ex_ready = (state==IDLE).
REQ-017 Accept = ex_valid && ex_ready; only accepted branches affect state, counters, or pulses.
REQ-018 SHALL evaluate on accept: eq/ne equality; blt/bge signed compare; bltu/bgeu unsigned compare; full XLEN width.
REQ-019 SHALL compute target = pc + imm modulo 2^XLEN, carry discarded.
REQ-020 branch_src 110/111 on accept: illegal=1 next cycle, not-taken, no redirect.
REQ-021 Taken with target[1:0]!=00: misalign=1 next cycle, no redirect, stay IDLE.
REQ-022 Taken, aligned: next edge register redir_pc=target, enter REDIRECT (latency 1 cycle accept->redir_valid).
REQ-023 Not-taken: stay IDLE, no redirect, no flush.
REQ-024 redir_valid = flush = (state==REDIRECT); redir_pc held stable while redir_valid=1 && redir_ready=0.
REQ-025 REDIRECT -> IDLE on edge where redir_ready=1; redir_ready=0 holds REDIRECT indefinitely.
REQ-026 redir_ready in IDLE SHALL be ignored.
REQ-027 ex_valid during REDIRECT SHALL be ignored (wrong-path), no counter change.
REQ-028 br_count +1 per accept (including illegal); taken_count +1 per redirect entered; both wrap 2^CNT_W-1 -> 0.
REQ-029 illegal/misalign pulses SHALL be exactly one cycle, else 0.

Reset
REQ-030 rst=1 at edge: state=IDLE, redir_valid=0, flush=0, redir_pc=0, illegal=0, misalign=0, counters=0.
REQ-031 rst SHALL dominate all other inputs, including mid-REDIRECT and simultaneous accept; no counter increment that cycle.
REQ-032 ex_ready=1 in the first cycle after reset deasserts.

Verification
REQ-033 beq, rs1=rs2=5, pc=0x100, imm=0x20, redir_ready=1 -> next cycle redir_valid=1, redir_pc=0x120, flush=1; following cycle IDLE; taken_count=1.
REQ-034 blt rs1=0xFFFFFFFF, rs2=1 -> taken; bltu same operands -> not-taken, no redir_valid; br_count=2, taken_count=1.
REQ-035 Taken branch, redir_ready=0 for 4 cycles -> redir_valid/flush/redir_pc stable 4 cycles, ex_ready=0, ex_valid ignored; exit on redir_ready=1.
REQ-036 branch_src=110 -> illegal one-cycle pulse, no redirect, br_count+1; bne target 0x102 -> misalign pulse, no redirect.
REQ-037 rst=1 while in REDIRECT -> next cycle redir_valid=0, flush=0, counters=0, ex_ready=1.
REQ-038 Preload counters to 2^CNT_W-1 via taken branches (reduced CNT_W=4) -> next taken wraps both to 0.
